// File: rtl/i2c_mst_ctrl_byte_pkg.sv
// Shared types and constants for the I2C master byte-level command sequencer.
`timescale 1ns/1ps
package i2c_mst_ctrl_byte_pkg;

   // Bit-controller command encodings (mirror of i2c_master_defines)
   localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
   localparam logic [3:0] I2C_CMD_START = 4'b0001;
   localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
   localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
   localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 3;

   // Byte sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WRITE = 3'd2,
      ST_READ  = 3'd3,
      ST_ACK   = 3'd4,
      ST_STOP  = 3'd5
   } byte_state_t;

endpackage

// File: rtl/i2c_mst_ctrl_byte.sv
// Byte-level command sequencer: expands start/write/read/stop requests into
// bit-controller commands, shifts tx/rx data and captures the acknowledge.
`timescale 1ns/1ps
module i2c_mst_ctrl_byte
   import i2c_mst_ctrl_byte_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        ena,
   input  logic        start,
   input  logic        stop,
   input  logic        read,
   input  logic        write,
   input  logic        ack_in,
   input  logic [7:0]  din,
   output logic        cmd_ack,
   output logic        ack_out,
   output logic [7:0]  dout,
   output logic        i2c_al,
   output logic [3:0]  bit_cmd,
   input  logic        bit_cmd_ack,
   input  logic        bit_al,
   output logic        bit_din,
   input  logic        bit_dout
);

   byte_state_t       state;
   logic [DATA_W-1:0] sr;
   logic [CNT_W-1:0]  cnt;
   logic              rd_byte;
   logic              req_c;

   // Any pending host request
   assign req_c = start | stop | read | write;

   // Received byte is the shift register itself
   assign dout = sr;

   // Sequencer FSM with registered bit-controller command, data and status
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         bit_cmd <= I2C_CMD_NOP;
         bit_din <= 1'b1;
         cmd_ack <= 1'b0;
         ack_out <= 1'b0;
         i2c_al  <= 1'b0;
         sr      <= '0;
         cnt     <= '0;
         rd_byte <= 1'b0;
      end else if (ena) begin
         cmd_ack <= 1'b0;
         i2c_al  <= 1'b0;
         if (bit_al) begin
            // Lost arbitration: drop the transfer, keep data registers
            state   <= ST_IDLE;
            bit_cmd <= I2C_CMD_NOP;
            bit_din <= 1'b1;
            i2c_al  <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  // The cmd_ack / i2c_al cycle blocks re-accepting a stale request
                  if (req_c && !cmd_ack && !i2c_al) begin
                     sr      <= din;
                     cnt     <= CNT_W'(DATA_W - 1);
                     rd_byte <= read;
                     if (start) begin
                        state   <= ST_START;
                        bit_cmd <= I2C_CMD_START;
                     end else if (read) begin
                        state   <= ST_READ;
                        bit_cmd <= I2C_CMD_READ;
                     end else if (write) begin
                        state   <= ST_WRITE;
                        bit_cmd <= I2C_CMD_WRITE;
                        bit_din <= din[7];
                     end else begin
                        state   <= ST_STOP;
                        bit_cmd <= I2C_CMD_STOP;
                     end
                  end
               end

               ST_START: begin
                  if (bit_cmd_ack) begin
                     if (read) begin
                        state   <= ST_READ;
                        bit_cmd <= I2C_CMD_READ;
                     end else if (write) begin
                        state   <= ST_WRITE;
                        bit_cmd <= I2C_CMD_WRITE;
                        bit_din <= sr[7];
                     end else if (stop) begin
                        state   <= ST_STOP;
                        bit_cmd <= I2C_CMD_STOP;
                     end else begin
                        state   <= ST_IDLE;
                        bit_cmd <= I2C_CMD_NOP;
                        cmd_ack <= 1'b1;
                     end
                  end
               end

               ST_WRITE: begin
                  if (bit_cmd_ack) begin
                     sr  <= {sr[DATA_W-2:0], 1'b0};
                     cnt <= cnt - CNT_W'(1);
                     if (cnt == '0) begin
                        // Sample the slave acknowledge
                        state   <= ST_ACK;
                        bit_cmd <= I2C_CMD_READ;
                        bit_din <= 1'b1;
                     end else begin
                        bit_din <= sr[DATA_W-2];
                     end
                  end
               end

               ST_READ: begin
                  if (bit_cmd_ack) begin
                     sr  <= {sr[DATA_W-2:0], bit_dout};
                     cnt <= cnt - CNT_W'(1);
                     if (cnt == '0) begin
                        // Drive the master acknowledge
                        state   <= ST_ACK;
                        bit_cmd <= I2C_CMD_WRITE;
                        bit_din <= ack_in;
                     end
                  end
               end

               ST_ACK: begin
                  if (bit_cmd_ack) begin
                     if (!rd_byte) begin
                        ack_out <= bit_dout;
                     end
                     bit_din <= 1'b1;
                     if (stop) begin
                        state   <= ST_STOP;
                        bit_cmd <= I2C_CMD_STOP;
                     end else begin
                        state   <= ST_IDLE;
                        bit_cmd <= I2C_CMD_NOP;
                        cmd_ack <= 1'b1;
                     end
                  end
               end

               ST_STOP: begin
                  if (bit_cmd_ack) begin
                     state   <= ST_IDLE;
                     bit_cmd <= I2C_CMD_NOP;
                     cmd_ack <= 1'b1;
                  end
               end

               default: begin
                  state   <= ST_IDLE;
                  bit_cmd <= I2C_CMD_NOP;
                  bit_din <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_mst_ctrl_byte.sv
// Self-checking bench for i2c_mst_ctrl_byte with a behavioural bit-controller.
`timescale 1ns/1ps
module tb_i2c_mst_ctrl_byte;
   import i2c_mst_ctrl_byte_pkg::*;

   logic       clk;
   logic       rstn;
   logic       ena;
   logic       start;
   logic       stop;
   logic       read;
   logic       write;
   logic       ack_in;
   logic [7:0] din;
   logic       cmd_ack;
   logic       ack_out;
   logic [7:0] dout;
   logic       i2c_al;
   logic [3:0] bit_cmd;
   logic       bit_cmd_ack;
   logic       bit_al;
   logic       bit_din;
   logic       bit_dout;

   int vectors = 0;
   int errors  = 0;

   i2c_mst_ctrl_byte dut (
      .clk         (clk),
      .rstn        (rstn),
      .ena         (ena),
      .start       (start),
      .stop        (stop),
      .read        (read),
      .write       (write),
      .ack_in      (ack_in),
      .din         (din),
      .cmd_ack     (cmd_ack),
      .ack_out     (ack_out),
      .dout        (dout),
      .i2c_al      (i2c_al),
      .bit_cmd     (bit_cmd),
      .bit_cmd_ack (bit_cmd_ack),
      .bit_al      (bit_al),
      .bit_din     (bit_din),
      .bit_dout    (bit_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef logic [4:0] cmd_q_t[$];

   // Observation log filled by the bit-controller model
   cmd_q_t     obs_cmd;
   bit         obs_ca[$];
   bit         rd_q[$];
   bit         m_busy = 0;
   int         m_cnt = 0;
   logic [3:0] m_cmd = 4'd0;
   int         m_wr_idx = 0;
   int         al_at_write = 0;
   bit         al_pending = 0;
   bit         al_seen = 0;
   bit         al_nop_ok = 0;
   int         al_high_cnt = 0;
   int         ca_rise_cnt = 0;
   bit         ca_prev = 0;
   bit         exp_ack_out = 0;

   // Bit-controller model: latches a command, acks it a few cycles later
   always @(negedge clk) begin
      if (!rstn) begin
         m_busy      = 0;
         bit_cmd_ack = 1'b0;
         bit_al      = 1'b0;
         al_pending  = 0;
         ca_prev     = 0;
      end else if (ena) begin
         if (i2c_al === 1'b1) al_high_cnt++;
         if (cmd_ack === 1'b1 && !ca_prev) ca_rise_cnt++;
         ca_prev = cmd_ack;
         if (al_pending) begin
            al_pending = 0;
            bit_al     = 1'b0;
            al_seen    = 1;
            al_nop_ok  = (bit_cmd === I2C_CMD_NOP) && (i2c_al === 1'b1) && (bit_din === 1'b1);
            m_busy     = 0;
         end else if (bit_cmd_ack) begin
            obs_ca.push_back(cmd_ack === 1'b1);
            bit_cmd_ack = 1'b0;
            m_busy      = 0;
         end else if (!m_busy) begin
            if (bit_cmd !== I2C_CMD_NOP) begin
               m_busy = 1;
               m_cnt  = 1;
               m_cmd  = bit_cmd;
               obs_cmd.push_back({bit_cmd, (bit_cmd == I2C_CMD_WRITE) ? bit_din : 1'b0});
               if (bit_cmd == I2C_CMD_WRITE) m_wr_idx++;
            end
         end else begin
            m_cnt++;
            if (m_cmd == I2C_CMD_WRITE && m_wr_idx == al_at_write && m_cnt == 3) begin
               bit_al     = 1'b1;
               al_pending = 1;
            end else if (m_cnt == 5) begin
               bit_cmd_ack = 1'b1;
               if (m_cmd == I2C_CMD_READ)
                  bit_dout = (rd_q.size() > 0) ? rd_q.pop_front() : 1'b1;
               else
                  bit_dout = 1'($urandom);
            end
         end
      end
   end

   // Reference: ordered bit commands for one request, {cmd, written bit}
   function automatic cmd_q_t ref_cmds(input bit s, input bit p, input bit r, input bit w,
                                       input logic [7:0] d, input bit a);
      cmd_q_t q;
      if (s) q.push_back({I2C_CMD_START, 1'b0});
      if (r) begin
         for (int i = 0; i < 8; i++) q.push_back({I2C_CMD_READ, 1'b0});
         q.push_back({I2C_CMD_WRITE, a});
      end else if (w) begin
         for (int i = 7; i >= 0; i--) q.push_back({I2C_CMD_WRITE, d[i]});
         q.push_back({I2C_CMD_READ, 1'b0});
      end
      if (p) q.push_back({I2C_CMD_STOP, 1'b0});
      return q;
   endfunction

   // Number of differences between the observed and an expected command list
   function automatic int seq_diffs(input cmd_q_t exp);
      int n;
      n = 0;
      if (obs_cmd.size() != exp.size()) return 1000 + obs_cmd.size();
      foreach (exp[i]) if (obs_cmd[i] !== exp[i]) n++;
      return n;
   endfunction

   // Number of command acks that were followed by cmd_ack
   function automatic int ca_ones();
      int n;
      n = 0;
      foreach (obs_ca[i]) if (obs_ca[i]) n++;
      return n;
   endfunction

   function automatic bit ca_last();
      return (obs_ca.size() > 0) ? obs_ca[obs_ca.size()-1] : 1'b0;
   endfunction

   // Drive one request until cmd_ack or i2c_al (bounded), then release it
   task automatic do_req(input bit s, input bit p, input bit r, input bit w,
                         input logic [7:0] d, input bit a, output bit done, output int lat);
      obs_cmd.delete();
      obs_ca.delete();
      m_wr_idx    = 0;
      al_high_cnt = 0;
      ca_rise_cnt = 0;
      @(posedge clk); #1;
      start = s; stop = p; read = r; write = w; din = d; ack_in = a;
      done = 0;
      lat  = -1;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (lat < 0 && bit_cmd !== I2C_CMD_NOP) lat = c + 1;
         if (cmd_ack === 1'b1 || i2c_al === 1'b1) begin
            done = 1;
            break;
         end
      end
      start = 0; stop = 0; read = 0; write = 0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; ena = 1'b1;
      start = 0; stop = 0; read = 0; write = 0; ack_in = 0; din = 8'h00;
      bit_cmd_ack = 0; bit_al = 0; bit_dout = 0;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (bit_cmd !== I2C_CMD_NOP) begin errors++; $display("FAIL reset_bit_cmd got %h want %h", bit_cmd, I2C_CMD_NOP); end
      vectors++; if (bit_din !== 1'b1) begin errors++; $display("FAIL reset_bit_din got %b want 1", bit_din); end
      vectors++; if (cmd_ack !== 1'b0) begin errors++; $display("FAIL reset_cmd_ack got %b want 0", cmd_ack); end
      vectors++; if (ack_out !== 1'b0) begin errors++; $display("FAIL reset_ack_out got %b want 0", ack_out); end
      vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
      vectors++; if (i2c_al !== 1'b0) begin errors++; $display("FAIL reset_i2c_al got %b want 0", i2c_al); end
      rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_start_write();
      bit done; int lat; int d;
      rd_q.push_back(1'b0);
      do_req(1, 0, 0, 1, 8'hA5, 0, done, lat);
      exp_ack_out = 0;
      vectors++; if (!done) begin errors++; $display("FAIL sw_timeout got 0 want 1"); end
      vectors++; if (lat !== 1) begin errors++; $display("FAIL sw_latency got %0d want 1", lat); end
      d = seq_diffs(ref_cmds(1, 0, 0, 1, 8'hA5, 0));
      vectors++; if (d != 0) begin errors++; $display("FAIL sw_seq diffs %0d got %0d cmds want 10", d, obs_cmd.size()); end
      vectors++; if (ca_ones() != 1 || !ca_last()) begin errors++; $display("FAIL sw_cmd_ack got %0d acks want 1 (last)", ca_ones()); end
      vectors++; if (ca_rise_cnt != 1) begin errors++; $display("FAIL sw_cmd_ack_pulses got %0d want 1", ca_rise_cnt); end
      vectors++; if (ack_out !== exp_ack_out) begin errors++; $display("FAIL sw_ack_out got %b want %b", ack_out, exp_ack_out); end
   endtask

   task automatic test_read();
      bit done; int lat; int d;
      bit pat [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
      foreach (pat[i]) rd_q.push_back(pat[i]);
      do_req(0, 0, 1, 0, 8'($urandom), 1, done, lat);
      vectors++; if (!done) begin errors++; $display("FAIL rd_timeout got 0 want 1"); end
      d = seq_diffs(ref_cmds(0, 0, 1, 0, 8'h00, 1));
      vectors++; if (d != 0) begin errors++; $display("FAIL rd_seq diffs %0d got %0d cmds want 9", d, obs_cmd.size()); end
      vectors++; if (dout !== 8'h3C) begin errors++; $display("FAIL rd_dout got %h want 3c", dout); end
      vectors++; if (ca_ones() != 1 || !ca_last()) begin errors++; $display("FAIL rd_cmd_ack got %0d acks want 1 (last)", ca_ones()); end
      vectors++; if (ack_out !== exp_ack_out) begin errors++; $display("FAIL rd_ack_out_hold got %b want %b", ack_out, exp_ack_out); end
   endtask

   task automatic test_write_stop();
      bit done; int lat; int d;
      rd_q.push_back(1'b1);
      do_req(0, 1, 0, 1, 8'h00, 0, done, lat);
      exp_ack_out = 1;
      vectors++; if (!done) begin errors++; $display("FAIL ws_timeout got 0 want 1"); end
      d = seq_diffs(ref_cmds(0, 1, 0, 1, 8'h00, 0));
      vectors++; if (d != 0) begin errors++; $display("FAIL ws_seq diffs %0d got %0d cmds want 10", d, obs_cmd.size()); end
      vectors++; if (ack_out !== exp_ack_out) begin errors++; $display("FAIL ws_ack_out got %b want %b", ack_out, exp_ack_out); end
      vectors++; if (ca_ones() != 1 || !ca_last()) begin errors++; $display("FAIL ws_cmd_ack_after_stop got %0d acks want 1 (last)", ca_ones()); end
   endtask

   task automatic test_arb_loss();
      bit done; int lat; int d;
      cmd_q_t exp;
      al_seen = 0; al_nop_ok = 0;
      al_at_write = 4;
      do_req(1, 0, 0, 1, 8'h5A, 0, done, lat);
      al_at_write = 0;
      exp = ref_cmds(1, 0, 0, 1, 8'h5A, 0);
      exp = exp[0:4];
      vectors++; if (!done) begin errors++; $display("FAIL al_timeout got 0 want 1"); end
      d = seq_diffs(exp);
      vectors++; if (d != 0) begin errors++; $display("FAIL al_seq diffs %0d got %0d cmds want 5", d, obs_cmd.size()); end
      vectors++; if (!(al_seen && al_nop_ok)) begin errors++; $display("FAIL al_nop_next seen %b ok %b want 1 1", al_seen, al_nop_ok); end
      vectors++; if (al_high_cnt != 1) begin errors++; $display("FAIL al_pulse_len got %0d want 1", al_high_cnt); end
      vectors++; if (ca_rise_cnt != 0 || ca_ones() != 0) begin errors++; $display("FAIL al_no_cmd_ack got %0d want 0", ca_rise_cnt + ca_ones()); end
      vectors++; if (ack_out !== exp_ack_out) begin errors++; $display("FAIL al_ack_out_hold got %b want %b", ack_out, exp_ack_out); end
      rd_q.push_back(1'b0);
      do_req(1, 0, 0, 1, 8'hFF, 0, done, lat);
      exp_ack_out = 0;
      d = seq_diffs(ref_cmds(1, 0, 0, 1, 8'hFF, 0));
      vectors++; if (!done || d != 0) begin errors++; $display("FAIL al_recover diffs %0d done %b want 0 1", d, done); end
      vectors++; if (ca_ones() != 1 || ack_out !== exp_ack_out) begin errors++; $display("FAIL al_recover_ack got %0d/%b want 1/%b", ca_ones(), ack_out, exp_ack_out); end
   endtask

   task automatic test_ena_freeze();
      bit done; int lat; int d; int chg;
      logic [7:0] rb; bit a; cmd_q_t ref_obs; logic [7:0] ref_dout;
      logic [15:0] snap;
      rb = 8'($urandom);
      a  = 1'($urandom);
      for (int i = 7; i >= 0; i--) rd_q.push_back(rb[i]);
      do_req(0, 0, 1, 0, 8'h00, a, done, lat);
      ref_obs  = obs_cmd;
      ref_dout = dout;
      for (int i = 7; i >= 0; i--) rd_q.push_back(rb[i]);
      chg = 0;
      fork
         do_req(0, 0, 1, 0, 8'h00, a, done, lat);
         begin
            repeat (30) @(posedge clk);
            #1;
            snap = {bit_cmd, bit_din, cmd_ack, ack_out, dout, i2c_al};
            ena = 1'b0;
            for (int i = 0; i < 20; i++) begin
               @(posedge clk); #1;
               if ({bit_cmd, bit_din, cmd_ack, ack_out, dout, i2c_al} !== snap) chg++;
            end
            ena = 1'b1;
         end
      join
      vectors++; if (chg != 0) begin errors++; $display("FAIL ena_frozen_outputs got %0d changes want 0", chg); end
      vectors++; if (!done) begin errors++; $display("FAIL ena_timeout got 0 want 1"); end
      d = seq_diffs(ref_obs);
      vectors++; if (d != 0) begin errors++; $display("FAIL ena_seq_same diffs %0d want 0", d); end
      d = seq_diffs(ref_cmds(0, 0, 1, 0, 8'h00, a));
      vectors++; if (d != 0) begin errors++; $display("FAIL ena_seq_ref diffs %0d want 0", d); end
      vectors++; if (dout !== rb || ref_dout !== rb) begin errors++; $display("FAIL ena_dout got %h/%h want %h", dout, ref_dout, rb); end
   endtask

   task automatic test_random_b2b();
      bit done; int lat; int d;
      bit s, p, r, w, a; logic [7:0] dd; logic [7:0] rb; bit ab;
      for (int k = 0; k < 10; k++) begin
         s = 1'($urandom); p = 1'($urandom); r = 1'($urandom); w = 1'($urandom);
         if (!(s || p || r || w)) w = 1;
         a  = 1'($urandom);
         dd = 8'($urandom);
         rb = 8'($urandom);
         ab = 1'($urandom);
         if (r) for (int i = 7; i >= 0; i--) rd_q.push_back(rb[i]);
         else if (w) rd_q.push_back(ab);
         do_req(s, p, r, w, dd, a, done, lat);
         if (!r && w) exp_ack_out = ab;
         d = seq_diffs(ref_cmds(s, p, r, w, dd, a));
         vectors++; if (!done || d != 0) begin errors++; $display("FAIL rnd%0d_seq diffs %0d done %b want 0 1 (s%b p%b r%b w%b)", k, d, done, s, p, r, w); end
         vectors++; if (ca_ones() != 1 || !ca_last()) begin errors++; $display("FAIL rnd%0d_cmd_ack got %0d want 1", k, ca_ones()); end
         vectors++; if (ack_out !== exp_ack_out) begin errors++; $display("FAIL rnd%0d_ack_out got %b want %b", k, ack_out, exp_ack_out); end
         if (r) begin
            vectors++; if (dout !== rb) begin errors++; $display("FAIL rnd%0d_dout got %h want %h", k, dout, rb); end
         end
      end
   endtask

   task automatic test_reset_mid_read();
      for (int i = 0; i < 8; i++) rd_q.push_back(1'b1);
      @(posedge clk); #1;
      read = 1; ack_in = 0;
      repeat (30) @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      vectors++; if (bit_cmd !== I2C_CMD_NOP) begin errors++; $display("FAIL rst_mid_bit_cmd got %h want %h", bit_cmd, I2C_CMD_NOP); end
      vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_mid_dout got %h want 00", dout); end
      vectors++; if (cmd_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_cmd_ack got %b want 0", cmd_ack); end
      vectors++; if (bit_din !== 1'b1) begin errors++; $display("FAIL rst_mid_bit_din got %b want 1", bit_din); end
      vectors++; if (ack_out !== 1'b0) begin errors++; $display("FAIL rst_mid_ack_out got %b want 0", ack_out); end
      read = 0;
      rd_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      exp_ack_out = 0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_start_write();
      test_read();
      test_write_stop();
      test_arb_loss();
      test_ena_freeze();
      test_random_b2b();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
